// File: rtl/hist_bin_sched.sv
// hist_bin_sched: arbitrates the 32-bin histogram bank between pixel increments and a read-and-clear CDF sweep.
module hist_bin_sched #(
  parameter int CNT_W = 16,
  parameter int SUM_W = 21
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pix_valid,
  input  logic [4:0]       pix_bin,
  output logic             pix_ready,
  input  logic             sweep_start,
  output logic             sweep_busy,
  output logic             sweep_done,
  output logic [31:0]      bin_sel,
  output logic             bin_inc,
  output logic             bin_rd,
  output logic             bin_clr,
  input  logic [CNT_W-1:0] bin_rdata,
  output logic             cdf_valid,
  output logic [4:0]       cdf_idx,
  output logic [SUM_W-1:0] cdf_data
);
  typedef enum logic [1:0] {IDLE, SWEEP, DRAIN} state_t;
  state_t state, state_n;
  logic [4:0] idx, idx_n;
  logic [SUM_W-1:0] sum;
  logic start, accept, last, rd_n;
  always_comb begin
    start     = state == IDLE && sweep_start;
    pix_ready = state == IDLE && !sweep_start;
    accept    = pix_valid && pix_ready;
    last      = state == SWEEP && idx == 5'd31;
    rd_n      = start || (state == SWEEP && !last);
    state_n   = start ? SWEEP : last ? DRAIN : state == DRAIN ? IDLE : state;
    idx_n     = start ? 5'd0 : state == SWEEP ? idx + 5'd1 : idx;
    // the returning read word is folded in the cycle it arrives
    cdf_data  = sum + (cdf_valid ? {{(SUM_W-CNT_W){1'b0}}, bin_rdata} : {SUM_W{1'b0}});
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      idx        <= '0;
      sum        <= '0;
      bin_sel    <= '0;
      bin_inc    <= 1'b0;
      bin_rd     <= 1'b0;
      bin_clr    <= 1'b0;
      cdf_valid  <= 1'b0;
      cdf_idx    <= '0;
      sweep_busy <= 1'b0;
      sweep_done <= 1'b0;
    end else begin
      state      <= state_n;
      idx        <= idx_n;
      sum        <= start ? '0 : cdf_valid ? cdf_data : sum;
      bin_sel    <= rd_n ? 32'd1 << idx_n : accept ? 32'd1 << pix_bin : 32'd0;
      bin_inc    <= accept;
      bin_rd     <= rd_n;
      bin_clr    <= rd_n;
      cdf_valid  <= bin_rd;
      cdf_idx    <= bin_rd ? idx : cdf_idx;
      sweep_busy <= state_n != IDLE;
      sweep_done <= last;
    end
  end
endmodule

// File: tb/tb_hist_bin_sched.sv
// tb_hist_bin_sched: directed and random stimulus against a count-the-pixels histogram reference.
module tb_hist_bin_sched;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        pix_valid, sweep_start, pix_ready, sweep_busy, sweep_done;
  logic        bin_inc, bin_rd, bin_clr, cdf_valid;
  logic [4:0]  pix_bin, cdf_idx;
  logic [31:0] bin_sel;
  logic [15:0] bin_rdata;
  logic [20:0] cdf_data;
  logic [15:0] bank [32];
  logic [15:0] load_val [32];
  logic        load;
  int          expc [32];
  int          errors = 0, checks = 0;

  hist_bin_sched dut (
    .clk(clk), .rst_n(rst_n), .pix_valid(pix_valid), .pix_bin(pix_bin),
    .pix_ready(pix_ready), .sweep_start(sweep_start), .sweep_busy(sweep_busy),
    .sweep_done(sweep_done), .bin_sel(bin_sel), .bin_inc(bin_inc), .bin_rd(bin_rd),
    .bin_clr(bin_clr), .bin_rdata(bin_rdata), .cdf_valid(cdf_valid),
    .cdf_idx(cdf_idx), .cdf_data(cdf_data)
  );

  always #5 clk = ~clk;

  function automatic int oh(input logic [31:0] s);
    for (int k = 0; k < 32; k++) if (s[k]) return k;
    return 0;
  endfunction

  // behavioural bank: read-before-clear, increment otherwise
  always @(posedge clk) begin
    if (load) for (int k = 0; k < 32; k++) bank[k] <= load_val[k];
    else begin
      if (bin_rd) bin_rdata <= bank[oh(bin_sel)];
      if (bin_clr) bank[oh(bin_sel)] <= 16'd0;
      else if (bin_inc) bank[oh(bin_sel)] <= bank[oh(bin_sel)] + 16'd1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_sel"}, bin_sel, 0);
    chk({tag, "_inc"}, bin_inc, 0);
    chk({tag, "_rd"}, bin_rd, 0);
    chk({tag, "_clr"}, bin_clr, 0);
    chk({tag, "_cv"}, cdf_valid, 0);
    chk({tag, "_ci"}, cdf_idx, 0);
    chk({tag, "_cd"}, cdf_data, 0);
    chk({tag, "_busy"}, sweep_busy, 0);
    chk({tag, "_done"}, sweep_done, 0);
  endtask

  task automatic preload(input int mode);
    for (int k = 0; k < 32; k++) begin
      load_val[k] = mode == 0 ? 16'(k + 1) : mode == 1 ? 16'hFFFF : 16'($urandom_range(0, 65535));
      expc[k] = int'(load_val[k]);
    end
    load = 1'b1;
    step();
    load = 1'b0;
  endtask

  task automatic run_sweep(input bit collide, input bit again, input int abort_at, output longint last_cdf);
    longint cum [32];
    longint acc = 0;
    int rds = 0;
    for (int k = 0; k < 32; k++) begin
      acc += expc[k];
      cum[k] = acc;
    end
    last_cdf = -1;
    sweep_start = 1'b1;
    pix_valid = collide;
    pix_bin = 5'd3;
    #1;
    chk("start_pix_ready", pix_ready, 0);
    step();
    sweep_start = 1'b0;
    pix_valid = 1'b0;
    for (int n = 1; n <= 34; n++) begin
      if (again && n == 5) sweep_start = 1'b1;
      if (n == abort_at) begin
        rst_n = 1'b0;
        #1;
        chk_zero("abort");
        chk("abort_pix_ready", pix_ready, 1);
        return;
      end
      #1;
      chk("sw_sel", bin_sel, n <= 32 ? 64'(32'd1 << (n - 1)) : 0);
      chk("sw_rd", bin_rd, n <= 32);
      chk("sw_clr", bin_clr, n <= 32);
      chk("sw_inc", bin_inc, 0);
      chk("sw_busy", sweep_busy, n <= 33);
      chk("sw_done", sweep_done, n == 33);
      chk("sw_cv", cdf_valid, n >= 2 && n <= 33);
      chk("sw_ready", pix_ready, n >= 34);
      if (n >= 2 && n <= 33) begin
        chk("sw_ci", cdf_idx, 64'(n - 2));
        chk("sw_cd", cdf_data, 64'(cum[n-2]));
        last_cdf = longint'(cdf_data);
      end
      rds += int'(bin_rd);
      step();
      sweep_start = 1'b0;
    end
    chk("sw_reads", rds, 32);
    for (int k = 0; k < 32; k++) expc[k] = 0;
  endtask

  initial begin
    longint last_cdf;
    logic pv;
    logic [4:0] pb;
    logic [4:0] dir [3];
    dir[0] = 5'd0; dir[1] = 5'd5; dir[2] = 5'd31;
    pix_valid = 1'b0; pix_bin = '0; sweep_start = 1'b0; load = 1'b0; rst_n = 1'b1;
    for (int k = 0; k < 32; k++) begin load_val[k] = '0; expc[k] = 0; end
    #2 rst_n = 1'b0;
    #1 chk_zero("reset");
    preload(1);
    for (int k = 0; k < 32; k++) begin load_val[k] = '0; expc[k] = 0; end
    load = 1'b1;
    step();
    load = 1'b0;
    rst_n = 1'b1;
    #1 chk("reset_ready", pix_ready, 1);
    for (int i = 0; i < 3; i++) begin
      pix_valid = 1'b1;
      pix_bin = dir[i];
      expc[dir[i]]++;
      step();
      chk("dir_sel", bin_sel, 64'(32'd1 << dir[i]));
      chk("dir_inc", bin_inc, 1);
      chk("dir_rd", bin_rd, 0);
      chk("dir_clr", bin_clr, 0);
    end
    pix_valid = 1'b0;
    step();
    chk("dir_idle_sel", bin_sel, 0);
    chk("dir_idle_inc", bin_inc, 0);
    for (int i = 0; i < 150; i++) begin
      pv = 1'($urandom_range(0, 1));
      pb = 5'($urandom_range(0, 31));
      pix_valid = pv;
      pix_bin = pb;
      #1 chk("rnd_ready", pix_ready, 1);
      if (pv) expc[pb]++;
      step();
      chk("rnd_inc", bin_inc, pv);
      chk("rnd_sel", bin_sel, pv ? 64'(32'd1 << pb) : 0);
    end
    pix_valid = 1'b0;
    step();
    run_sweep(1'b0, 1'b0, 0, last_cdf);
    preload(0);
    run_sweep(1'b1, 1'b1, 0, last_cdf);
    chk("ramp_final", last_cdf, 528);
    preload(1);
    run_sweep(1'b0, 1'b0, 0, last_cdf);
    chk("sat_final", last_cdf, 64'h1FFFE0);
    preload(2);
    run_sweep(1'b0, 1'b0, 11, last_cdf);
    for (int k = 0; k < 10; k++) expc[k] = 0;
    step();
    rst_n = 1'b1;
    step();
    run_sweep(1'b0, 1'b0, 0, last_cdf);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
